// File: rtl/stage_mem.sv
// stage_mem: MIPS MEM stage, executes byte/half/word loads and stores over a req/ack data bus
module stage_mem #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_i,
  input  logic [7:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        reg_write_enable_i,
  input  logic [4:0]  reg_write_address_i,
  input  logic [31:0] reg_write_data_i,
  output logic        reg_write_enable_o,
  output logic [4:0]  reg_write_address_o,
  output logic [31:0] reg_write_data_o,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic        stall_request
);
  localparam logic [7:0] OP_LB = 8'h20, OP_LH = 8'h21, OP_LW = 8'h23, OP_LBU = 8'h24,
                         OP_LHU = 8'h25, OP_SB = 8'h28, OP_SH = 8'h29, OP_SW = 8'h2B;
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [31:0] ea, wdata, rdata_q, load;
  logic is_b, is_h, is_w, is_st, is_mem, mis, timeout, we_q, to_q;
  logic [3:0] be;
  logic [7:0] op_q, byte_q;
  logic [15:0] half_q;
  logic [1:0] lane_q;
  logic [4:0] rd_q;
  logic [CW-1:0] cnt;
  logic unused;
  assign unused = ^instruction_i[31:16];
  always_comb begin
    ea = operand_a_i + {{16{instruction_i[15]}}, instruction_i[15:0]};
    is_b = operator_i inside {OP_LB, OP_LBU, OP_SB};
    is_h = operator_i inside {OP_LH, OP_LHU, OP_SH};
    is_w = operator_i inside {OP_LW, OP_SW};
    is_st = operator_i inside {OP_SB, OP_SH, OP_SW};
    is_mem = is_b | is_h | is_w;
    mis = (is_h & ea[0]) | (is_w & |ea[1:0]);
    be = is_b ? 4'b0001 << ea[1:0] : is_h ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = is_b ? {4{operand_b_i[7:0]}} : is_h ? {2{operand_b_i[15:0]}} : operand_b_i;
    timeout = ACK_TIMEOUT != 0 && cnt == CW'(ACK_TIMEOUT - 1);
    byte_q = rdata_q[8*lane_q +: 8];
    half_q = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load = op_q == OP_LB  ? {{24{byte_q[7]}}, byte_q} :
           op_q == OP_LBU ? {24'h0, byte_q} :
           op_q == OP_LH  ? {{16{half_q[15]}}, half_q} :
           op_q == OP_LHU ? {16'h0, half_q} : rdata_q;
    reg_write_enable_o = reset ? 1'b0 : state == DONE ? we_q :
                         state == IDLE & reg_write_enable_i & ~is_mem;
    reg_write_address_o = reset ? 5'd0 : state == DONE ? rd_q : reg_write_address_i;
    reg_write_data_o = reset ? 32'd0 : state == DONE ? load : reg_write_data_i;
    stall_request = ~reset & (state == BUSY | (state == IDLE & is_mem & ~mis));
    bus_error = ~reset & ((state == IDLE & is_mem & mis) | to_q);
  end
  // to_q carries a timeout into the DONE cycle so bus_error pulses there
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mem_request <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= 32'd0;
      mem_byte_enable <= 4'd0;
      mem_write_data <= 32'd0;
      cnt <= '0;
      op_q <= 8'd0;
      lane_q <= 2'd0;
      rd_q <= 5'd0;
      we_q <= 1'b0;
      to_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          to_q <= 1'b0;
          if (is_mem & ~mis) begin
            state <= BUSY;
            mem_request <= 1'b1;
            mem_write <= is_st;
            mem_address <= {ea[31:2], 2'b00};
            mem_byte_enable <= be;
            mem_write_data <= is_st ? wdata : 32'd0;
            op_q <= operator_i;
            lane_q <= ea[1:0];
            rd_q <= reg_write_address_i;
            we_q <= reg_write_enable_i & ~is_st;
            cnt <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_request <= 1'b0;
            rdata_q <= mem_read_data;
            state <= DONE;
          end else if (timeout) begin
            mem_request <= 1'b0;
            we_q <= 1'b0;
            to_q <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + CW'(1);
        end
        DONE: begin
          to_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed checks of passthrough, loads, stores, misalignment, timeout and reset
module tb_stage_mem;
  localparam logic [7:0] OP_ADDU = 8'h01, OP_LB = 8'h20, OP_LH = 8'h21, OP_LW = 8'h23, OP_LBU = 8'h24,
                         OP_LHU = 8'h25, OP_SB = 8'h28, OP_SH = 8'h29, OP_SW = 8'h2B;
  logic clock = 0, reset = 1;
  logic [31:0] instruction_i = 0, operand_a_i = 0, operand_b_i = 0, reg_write_data_i = 0, mem_read_data = 0;
  logic [7:0] operator_i = OP_ADDU;
  logic reg_write_enable_i = 0, mem_ack = 0;
  logic [4:0] reg_write_address_i = 0;
  logic reg_write_enable_o, mem_request, mem_write, bus_error, stall_request;
  logic [4:0] reg_write_address_o;
  logic [31:0] reg_write_data_o, mem_address, mem_write_data;
  logic [3:0] mem_byte_enable;
  int checks = 0, failures = 0;
  logic s_idle, s_req, s_wr, s_busy, d_we, d_stall;
  logic [31:0] s_addr, s_wd, d_wd;
  logic [3:0] s_be;
  logic [4:0] d_wa;

  stage_mem #(.ACK_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .instruction_i(instruction_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .reg_write_enable_i(reg_write_enable_i),
    .reg_write_address_i(reg_write_address_i), .reg_write_data_i(reg_write_data_i),
    .reg_write_enable_o(reg_write_enable_o), .reg_write_address_o(reg_write_address_o),
    .reg_write_data_o(reg_write_data_o), .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack), .bus_error(bus_error), .stall_request(stall_request)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] off, input logic we, input logic [4:0] rd, input logic [31:0] wd);
    operator_i = op; operand_a_i = a; operand_b_i = b; instruction_i = {16'h0, off};
    reg_write_enable_i = we; reg_write_address_i = rd; reg_write_data_i = wd;
  endtask

  // issue one memory op with ack on the first BUSY cycle; record what was seen in each phase
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] off, input logic [31:0] rdata);
    @(negedge clock);
    drive(op, a, b, off, 1'b1, 5'd7, 32'h0);
    #1 s_idle = stall_request;
    @(negedge clock);
    s_req = mem_request; s_wr = mem_write; s_addr = mem_address; s_be = mem_byte_enable;
    s_wd = mem_write_data; s_busy = stall_request;
    mem_ack = 1; mem_read_data = rdata;
    @(negedge clock);
    mem_ack = 0; mem_read_data = 0;
    d_we = reg_write_enable_o; d_wd = reg_write_data_o; d_wa = reg_write_address_o; d_stall = stall_request;
    drive(OP_ADDU, 0, 0, 0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset;
    drive(OP_ADDU, 0, 0, 0, 1'b1, 5'd5, 32'h1234);
    #12;
    checks++; if (reg_write_enable_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", reg_write_enable_o); end
    checks++; if (reg_write_data_o !== 32'h0) begin failures++; $display("FAIL rst_wd got=%h exp=0", reg_write_data_o); end
    checks++; if ({mem_request, mem_write, mem_byte_enable} !== 6'h0) begin failures++; $display("FAIL rst_bus got=%b exp=0", {mem_request, mem_write, mem_byte_enable}); end
    checks++; if ({mem_address, mem_write_data} !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", {mem_address, mem_write_data}); end
    checks++; if ({stall_request, bus_error} !== 2'b00) begin failures++; $display("FAIL rst_stall got=%b exp=00", {stall_request, bus_error}); end
    @(negedge clock) reset = 0;
  endtask

  task automatic test_passthrough;
    @(negedge clock);
    drive(OP_ADDU, 32'h1, 32'h2, 16'h0, 1'b1, 5'd5, 32'h1234);
    mem_ack = 1;
    #1;
    checks++; if ({reg_write_enable_o, reg_write_address_o, reg_write_data_o} !== {1'b1, 5'd5, 32'h1234}) begin failures++; $display("FAIL pass_out got=%b/%0d/%h exp=1/5/1234", reg_write_enable_o, reg_write_address_o, reg_write_data_o); end
    checks++; if ({stall_request, mem_request, bus_error} !== 3'b000) begin failures++; $display("FAIL pass_ctl got=%b exp=000", {stall_request, mem_request, bus_error}); end
    @(negedge clock);
    mem_ack = 0;
    checks++; if ({mem_request, stall_request, reg_write_data_o} !== {2'b00, 32'h1234}) begin failures++; $display("FAIL idle_ack got=%b%b/%h exp=00/1234", mem_request, stall_request, reg_write_data_o); end
    drive(OP_ADDU, 0, 0, 0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_lw;
    do_op(OP_LW, 32'h100, 32'h0, 16'hFFFC, 32'hDEADBEEF);
    checks++; if ({s_idle, s_busy, d_stall} !== 3'b110) begin failures++; $display("FAIL lw_stall got=%b exp=110", {s_idle, s_busy, d_stall}); end
    checks++; if ({s_req, s_wr, s_addr, s_be} !== {2'b10, 32'hFC, 4'b1111}) begin failures++; $display("FAIL lw_bus got=%b%b/%h/%b exp=10/fc/1111", s_req, s_wr, s_addr, s_be); end
    checks++; if ({d_we, d_wa, d_wd} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin failures++; $display("FAIL lw_done got=%b/%0d/%h exp=1/7/deadbeef", d_we, d_wa, d_wd); end
    checks++; if (mem_request !== 1'b0) begin failures++; $display("FAIL lw_reqdrop got=%b exp=0", mem_request); end
  endtask

  task automatic test_subword_loads;
    do_op(OP_LB, 32'h203, 32'h0, 16'h0, 32'h80000000);
    checks++; if ({s_addr, s_be} !== {32'h200, 4'b1000}) begin failures++; $display("FAIL lb_bus got=%h/%b exp=200/1000", s_addr, s_be); end
    checks++; if (d_wd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", d_wd); end
    do_op(OP_LBU, 32'h203, 32'h0, 16'h0, 32'h80000000);
    checks++; if (d_wd !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", d_wd); end
    do_op(OP_LH, 32'h200, 32'h0, 16'h0002, 32'h8001_7F00);
    checks++; if ({s_be, d_wd} !== {4'b1100, 32'hFFFF8001}) begin failures++; $display("FAIL lh_data got=%b/%h exp=1100/ffff8001", s_be, d_wd); end
    do_op(OP_LHU, 32'h204, 32'h0, 16'hFFFE, 32'h8001_7F00);
    checks++; if ({s_addr, d_wd} !== {32'h200, 32'h00008001}) begin failures++; $display("FAIL lhu_data got=%h/%h exp=200/00008001", s_addr, d_wd); end
  endtask

  task automatic test_stores;
    do_op(OP_SH, 32'h12, 32'hAAAA5555, 16'h0, 32'h0);
    checks++; if ({s_wr, s_be, s_wd, s_addr} !== {1'b1, 4'b1100, 32'h55555555, 32'h10}) begin failures++; $display("FAIL sh_bus got=%b/%b/%h/%h exp=1/1100/55555555/10", s_wr, s_be, s_wd, s_addr); end
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL sh_we got=%b exp=0", d_we); end
    do_op(OP_SB, 32'h201, 32'h12345678, 16'h0, 32'h0);
    checks++; if ({s_be, s_wd} !== {4'b0010, 32'h78787878}) begin failures++; $display("FAIL sb_bus got=%b/%h exp=0010/78787878", s_be, s_wd); end
    do_op(OP_SW, 32'h300, 32'hCAFEF00D, 16'h4, 32'h0);
    checks++; if ({s_addr, s_be, s_wd, d_we} !== {32'h304, 4'b1111, 32'hCAFEF00D, 1'b0}) begin failures++; $display("FAIL sw_bus got=%h/%b/%h/%b exp=304/1111/cafef00d/0", s_addr, s_be, s_wd, d_we); end
  endtask

  task automatic test_misaligned;
    @(negedge clock);
    drive(OP_LW, 32'h2, 32'h0, 16'h0, 1'b1, 5'd9, 32'h0);
    #1;
    checks++; if ({bus_error, stall_request, reg_write_enable_o} !== 3'b100) begin failures++; $display("FAIL mis_ctl got=%b exp=100", {bus_error, stall_request, reg_write_enable_o}); end
    #1 drive(OP_ADDU, 0, 0, 0, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    checks++; if ({mem_request, bus_error, stall_request} !== 3'b000) begin failures++; $display("FAIL mis_after got=%b exp=000", {mem_request, bus_error, stall_request}); end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    @(negedge clock);
    drive(OP_LW, 32'h100, 32'h0, 16'h0, 1'b1, 5'd4, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (stall_request && mem_request && !bus_error) n++;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL to_busy got=%0d exp=16", n); end
    @(negedge clock);
    checks++; if ({bus_error, reg_write_enable_o, mem_request, stall_request} !== 4'b1000) begin failures++; $display("FAIL to_done got=%b exp=1000", {bus_error, reg_write_enable_o, mem_request, stall_request}); end
    drive(OP_ADDU, 0, 0, 0, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0", bus_error); end
  endtask

  task automatic test_reset_busy;
    @(negedge clock);
    drive(OP_LW, 32'h100, 32'h0, 16'h0, 1'b1, 5'd4, 32'h0);
    @(negedge clock);
    checks++; if (mem_request !== 1'b1) begin failures++; $display("FAIL rb_req got=%b exp=1", mem_request); end
    #2 reset = 1;
    #1;
    checks++; if ({mem_request, stall_request, reg_write_enable_o} !== 3'b000) begin failures++; $display("FAIL rb_async got=%b exp=000", {mem_request, stall_request, reg_write_enable_o}); end
    @(negedge clock);
    reset = 0;
    drive(OP_ADDU, 0, 0, 0, 1'b1, 5'd3, 32'h55);
    mem_ack = 1; mem_read_data = 32'hFFFFFFFF;
    @(negedge clock);
    mem_ack = 0;
    checks++; if ({mem_request, stall_request, bus_error, reg_write_enable_o, reg_write_data_o} !== {4'b0001, 32'h55}) begin failures++; $display("FAIL rb_ack got=%b/%h exp=0001/55", {mem_request, stall_request, bus_error, reg_write_enable_o}, reg_write_data_o); end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_lw;
    test_subword_loads;
    test_stores;
    test_misaligned;
    test_timeout;
    test_reset_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
